// File: rtl/fpu_jm_pkg.sv
// Shared types and constants for the FPU job dispatcher (fpu_job_dispatcher, fpu_port_mux).
package fpu_jm_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2,
    ERR  = 2'd3
  } state_e;

  localparam logic [3:0] LINEAR_FW  = 4'd0;
  localparam logic [3:0] LINEAR_BW  = 4'd1;
  localparam logic [3:0] FLATTEN_FW = 4'd2;
  localparam logic [3:0] FLATTEN_BW = 4'd3;

  localparam int unsigned DEF_NUM_KERNELS = 4;
  localparam int unsigned DEF_NUM_PORTS   = 4;
  localparam int unsigned DEF_ADDR_W      = 32;
  localparam int unsigned DEF_DATA_W      = 32;
  localparam int unsigned DEF_NUM_REGS    = 32;
  localparam int unsigned DEF_OP_W        = 4;
  localparam int unsigned DEF_CTR_W       = 4;

  function automatic int unsigned bundle_w(input int unsigned num_ports, input int unsigned w);
    return num_ports * w;
  endfunction

  function automatic int unsigned sel_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fpu_port_mux.sv
// NUM_KERNELS-to-1 memory-bundle mux/demux: the selected kernel talks to memory only while
// run_en_i is high; every other kernel port and all memory-side outputs read zero.
module fpu_port_mux
  import fpu_jm_pkg::*;
#(
  parameter int unsigned NUM_KERNELS = DEF_NUM_KERNELS,
  parameter int unsigned NUM_PORTS   = DEF_NUM_PORTS,
  parameter int unsigned ADDR_W      = DEF_ADDR_W,
  parameter int unsigned DATA_W      = DEF_DATA_W,
  parameter int unsigned SEL_W       = sel_w(DEF_NUM_KERNELS)
) (
  input  logic [SEL_W-1:0]                      sel_i,
  input  logic                                  run_en_i,
  input  logic [NUM_PORTS*ADDR_W-1:0]           mem_region_begin_i,
  input  logic [NUM_PORTS*ADDR_W-1:0]           mem_region_end_i,
  input  logic [NUM_PORTS*DATA_W-1:0]           mem_data_load_i,
  input  logic [NUM_PORTS-1:0]                  mem_done_i,
  output logic [NUM_PORTS-1:0]                  mem_w_en_o,
  output logic [NUM_PORTS-1:0]                  mem_r_en_o,
  output logic [NUM_PORTS-1:0]                  mem_avail_o,
  output logic [NUM_PORTS*ADDR_W-1:0]           mem_ptr_o,
  output logic [NUM_PORTS*DATA_W-1:0]           mem_data_store_o,
  input  logic [NUM_KERNELS*NUM_PORTS-1:0]        k_w_en_i,
  input  logic [NUM_KERNELS*NUM_PORTS-1:0]        k_r_en_i,
  input  logic [NUM_KERNELS*NUM_PORTS-1:0]        k_avail_i,
  input  logic [NUM_KERNELS*NUM_PORTS*ADDR_W-1:0] k_ptr_i,
  input  logic [NUM_KERNELS*NUM_PORTS*DATA_W-1:0] k_data_store_i,
  output logic [NUM_KERNELS*NUM_PORTS*ADDR_W-1:0] k_region_begin_o,
  output logic [NUM_KERNELS*NUM_PORTS*ADDR_W-1:0] k_region_end_o,
  output logic [NUM_KERNELS*NUM_PORTS*DATA_W-1:0] k_data_load_o,
  output logic [NUM_KERNELS*NUM_PORTS-1:0]        k_mem_done_o
);

  localparam int unsigned PA = bundle_w(NUM_PORTS, ADDR_W);
  localparam int unsigned PD = bundle_w(NUM_PORTS, DATA_W);

  always_comb begin
    mem_w_en_o       = '0;
    mem_r_en_o       = '0;
    mem_avail_o      = '0;
    mem_ptr_o        = '0;
    mem_data_store_o = '0;
    k_region_begin_o = '0;
    k_region_end_o   = '0;
    k_data_load_o    = '0;
    k_mem_done_o     = '0;
    for (int unsigned k = 0; k < NUM_KERNELS; k++) begin
      if (run_en_i && (sel_i == SEL_W'(k))) begin
        mem_w_en_o                        = k_w_en_i[k*NUM_PORTS +: NUM_PORTS];
        mem_r_en_o                        = k_r_en_i[k*NUM_PORTS +: NUM_PORTS];
        mem_avail_o                       = k_avail_i[k*NUM_PORTS +: NUM_PORTS];
        mem_ptr_o                         = k_ptr_i[k*PA +: PA];
        mem_data_store_o                  = k_data_store_i[k*PD +: PD];
        k_region_begin_o[k*PA +: PA]      = mem_region_begin_i;
        k_region_end_o[k*PA +: PA]        = mem_region_end_i;
        k_data_load_o[k*PD +: PD]         = mem_data_load_i;
        k_mem_done_o[k*NUM_PORTS +: NUM_PORTS] = mem_done_i;
      end
    end
  end

endmodule

// File: rtl/fpu_job_dispatcher.sv
// FPU job manager: decodes op to a kernel, routes its memory bundles, latches results.
// Optional watchdog on RUN enabled by defining FPU_JM_TIMEOUT_EN.
module fpu_job_dispatcher
  import fpu_jm_pkg::*;
#(
  parameter int unsigned NUM_KERNELS    = DEF_NUM_KERNELS,
  parameter int unsigned NUM_PORTS      = DEF_NUM_PORTS,
  parameter int unsigned ADDR_W         = DEF_ADDR_W,
  parameter int unsigned DATA_W         = DEF_DATA_W,
  parameter int unsigned NUM_REGS       = DEF_NUM_REGS,
  parameter int unsigned OP_W           = DEF_OP_W,
  parameter int unsigned CTR_W          = DEF_CTR_W,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic                                  clk,
  input  logic                                  rst_l,
  input  logic                                  avail,
  input  logic [OP_W-1:0]                       op,
  output logic                                  done,
  output logic                                  err,
  output logic                                  busy,
  output logic [CTR_W-1:0]                      port_ctr,
  input  logic [NUM_PORTS*ADDR_W-1:0]           mem_region_begin,
  input  logic [NUM_PORTS*ADDR_W-1:0]           mem_region_end,
  input  logic [NUM_PORTS*DATA_W-1:0]           mem_data_load,
  input  logic [NUM_PORTS-1:0]                  mem_done,
  output logic [NUM_PORTS-1:0]                  mem_w_en,
  output logic [NUM_PORTS-1:0]                  mem_r_en,
  output logic [NUM_PORTS-1:0]                  mem_avail,
  output logic [NUM_PORTS*ADDR_W-1:0]           mem_ptr,
  output logic [NUM_PORTS*DATA_W-1:0]           mem_data_store,
  output logic [NUM_KERNELS-1:0]                k_go,
  input  logic [NUM_KERNELS-1:0]                k_done,
  input  logic [NUM_KERNELS*NUM_PORTS-1:0]        k_w_en,
  input  logic [NUM_KERNELS*NUM_PORTS-1:0]        k_r_en,
  input  logic [NUM_KERNELS*NUM_PORTS-1:0]        k_avail,
  input  logic [NUM_KERNELS*NUM_PORTS*ADDR_W-1:0] k_ptr,
  input  logic [NUM_KERNELS*NUM_PORTS*DATA_W-1:0] k_data_store,
  output logic [NUM_KERNELS*NUM_PORTS*ADDR_W-1:0] k_region_begin,
  output logic [NUM_KERNELS*NUM_PORTS*ADDR_W-1:0] k_region_end,
  output logic [NUM_KERNELS*NUM_PORTS*DATA_W-1:0] k_data_load,
  output logic [NUM_KERNELS*NUM_PORTS-1:0]        k_mem_done,
  input  logic [NUM_KERNELS*NUM_REGS*DATA_W-1:0]  k_r,
  output logic [NUM_REGS*DATA_W-1:0]            r
);

  localparam int unsigned SEL_W = sel_w(NUM_KERNELS);
  localparam int unsigned RW    = NUM_REGS * DATA_W;
  localparam logic [OP_W:0] OP_LIM = (OP_W+1)'(NUM_KERNELS);

  state_e           state_q, state_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [CTR_W-1:0] ctr_q, ctr_d;
  logic [RW-1:0]    r_q, r_d;
  logic [RW-1:0]    k_r_sel;
  logic             op_ok;
  logic             sel_done;

`ifdef FPU_JM_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
`endif

  assign op_ok = ({1'b0, op} < OP_LIM);

  always_comb begin
    sel_done = 1'b0;
    k_r_sel  = '0;
    for (int unsigned k = 0; k < NUM_KERNELS; k++) begin
      if (sel_q == SEL_W'(k)) begin
        sel_done = k_done[k];
        k_r_sel  = k_r[k*RW +: RW];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    ctr_d   = ctr_q;
    r_d     = r_q;
`ifdef FPU_JM_TIMEOUT_EN
    to_cnt_d = to_cnt_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (avail) begin
          if (op_ok) begin
            state_d = RUN;
            sel_d   = op[SEL_W-1:0];
`ifdef FPU_JM_TIMEOUT_EN
            to_cnt_d = '0;
`endif
          end else begin
            state_d = ERR;
          end
        end
      end
      RUN: begin
        // Completion takes priority over a watchdog expiry in the same cycle.
        if (sel_done) begin
          state_d = DONE;
          r_d     = k_r_sel;
        end
`ifdef FPU_JM_TIMEOUT_EN
        else if (to_cnt_q == TO_LAST) begin
          state_d = ERR;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
`endif
      end
      DONE, ERR: begin
        if (!avail) begin
          state_d = IDLE;
          ctr_d   = ctr_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state_q <= IDLE;
      sel_q   <= '0;
      ctr_q   <= '0;
      r_q     <= '0;
`ifdef FPU_JM_TIMEOUT_EN
      to_cnt_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      ctr_q   <= ctr_d;
      r_q     <= r_d;
`ifdef FPU_JM_TIMEOUT_EN
      to_cnt_q <= to_cnt_d;
`endif
    end
  end

  assign done     = (state_q == DONE) || (state_q == ERR);
  assign err      = (state_q == ERR);
  assign busy     = (state_q == RUN);
  assign port_ctr = ctr_q;
  assign r        = r_q;

  always_comb begin
    k_go = '0;
    for (int unsigned k = 0; k < NUM_KERNELS; k++) begin
      k_go[k] = busy && (sel_q == SEL_W'(k));
    end
  end

  fpu_port_mux #(
    .NUM_KERNELS(NUM_KERNELS),
    .NUM_PORTS  (NUM_PORTS),
    .ADDR_W     (ADDR_W),
    .DATA_W     (DATA_W),
    .SEL_W      (SEL_W)
  ) u_port_mux (
    .sel_i             (sel_q),
    .run_en_i          (busy),
    .mem_region_begin_i(mem_region_begin),
    .mem_region_end_i  (mem_region_end),
    .mem_data_load_i   (mem_data_load),
    .mem_done_i        (mem_done),
    .mem_w_en_o        (mem_w_en),
    .mem_r_en_o        (mem_r_en),
    .mem_avail_o       (mem_avail),
    .mem_ptr_o         (mem_ptr),
    .mem_data_store_o  (mem_data_store),
    .k_w_en_i          (k_w_en),
    .k_r_en_i          (k_r_en),
    .k_avail_i         (k_avail),
    .k_ptr_i           (k_ptr),
    .k_data_store_i    (k_data_store),
    .k_region_begin_o  (k_region_begin),
    .k_region_end_o    (k_region_end),
    .k_data_load_o     (k_data_load),
    .k_mem_done_o      (k_mem_done)
  );

endmodule

// File: tb/tb_fpu_job_dispatcher.sv
// Self-checking bench for fpu_job_dispatcher: job-level reference model plus directed jobs.
module tb_fpu_job_dispatcher;

  localparam int NK = 4;
  localparam int NP = 2;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int NR = 8;
  localparam int OW = 4;
  localparam int CW = 4;
  localparam int TO = 10;
  localparam int KP = NK * NP;

  logic clk = 1'b0;
  logic rst_l;
  logic avail;
  logic [OW-1:0] op;
  logic done, err, busy;
  logic [CW-1:0] port_ctr;
  logic [NP*AW-1:0] mem_region_begin, mem_region_end, mem_ptr;
  logic [NP*DW-1:0] mem_data_load, mem_data_store;
  logic [NP-1:0] mem_done, mem_w_en, mem_r_en, mem_avail;
  logic [NK-1:0] k_go, k_done;
  logic [KP-1:0] k_w_en, k_r_en, k_avail, k_mem_done;
  logic [KP*AW-1:0] k_ptr, k_region_begin, k_region_end;
  logic [KP*DW-1:0] k_data_store, k_data_load;
  logic [NK*NR*DW-1:0] k_r;
  logic [NR*DW-1:0] r;

  int tests = 0;
  int fails = 0;

  fpu_job_dispatcher #(
    .NUM_KERNELS(NK), .NUM_PORTS(NP), .ADDR_W(AW), .DATA_W(DW),
    .NUM_REGS(NR), .OP_W(OW), .CTR_W(CW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst_l(rst_l), .avail(avail), .op(op),
    .done(done), .err(err), .busy(busy), .port_ctr(port_ctr),
    .mem_region_begin(mem_region_begin), .mem_region_end(mem_region_end),
    .mem_data_load(mem_data_load), .mem_done(mem_done),
    .mem_w_en(mem_w_en), .mem_r_en(mem_r_en), .mem_avail(mem_avail),
    .mem_ptr(mem_ptr), .mem_data_store(mem_data_store),
    .k_go(k_go), .k_done(k_done),
    .k_w_en(k_w_en), .k_r_en(k_r_en), .k_avail(k_avail),
    .k_ptr(k_ptr), .k_data_store(k_data_store),
    .k_region_begin(k_region_begin), .k_region_end(k_region_end),
    .k_data_load(k_data_load), .k_mem_done(k_mem_done),
    .k_r(k_r), .r(r)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic rnd();
    for (int i = 0; i < NP; i++) begin
      mem_region_begin[i*AW +: AW] = $urandom;
      mem_region_end[i*AW +: AW]   = $urandom;
      mem_data_load[i*DW +: DW]    = $urandom;
    end
    mem_done = NP'($urandom);
    for (int i = 0; i < KP; i++) begin
      k_ptr[i*AW +: AW]        = $urandom;
      k_data_store[i*DW +: DW] = $urandom;
    end
    k_w_en  = KP'($urandom);
    k_r_en  = KP'($urandom);
    k_avail = KP'($urandom);
    for (int i = 0; i < NK*NR; i++) k_r[i*DW +: DW] = $urandom;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    rnd();
  endtask

  // Job-level reference: a job is either running on m_sel, finished (awaiting avail low), or absent.
  bit          m_run, m_fin, m_err;
  int          m_sel, m_cnt;
  bit [CW-1:0] m_ctr;
  bit [DW-1:0] m_r [NR];

  always @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      m_run = 0; m_fin = 0; m_err = 0; m_sel = 0; m_cnt = 0; m_ctr = '0;
      for (int i = 0; i < NR; i++) m_r[i] = '0;
    end else if (m_fin) begin
      if (!avail) begin
        m_fin = 0; m_err = 0; m_ctr = m_ctr + 1'b1;
      end
    end else if (m_run) begin
      if (k_done[m_sel]) begin
        m_run = 0; m_fin = 1;
        for (int i = 0; i < NR; i++) m_r[i] = k_r[(m_sel*NR + i)*DW +: DW];
      end
`ifdef FPU_JM_TIMEOUT_EN
      else begin
        m_cnt++;
        if (m_cnt == TO) begin
          m_run = 0; m_fin = 1; m_err = 1;
        end
      end
`endif
    end else if (avail) begin
      if (int'(op) < NK) begin
        m_run = 1; m_sel = int'(op); m_cnt = 0;
      end else begin
        m_fin = 1; m_err = 1;
      end
    end
  end

  always @(negedge clk) begin
    logic [NP*AW-1:0] e_ptr;
    logic [NP*DW-1:0] e_st;
    logic [NP-1:0]    e_w, e_rd, e_av;
    logic [KP*AW-1:0] e_rb, e_re;
    logic [KP*DW-1:0] e_dl;
    logic [KP-1:0]    e_md;
    logic [NK-1:0]    e_go;
    logic [NR*DW-1:0] e_r;
    e_ptr = '0; e_st = '0; e_w = '0; e_rd = '0; e_av = '0;
    e_rb = '0; e_re = '0; e_dl = '0; e_md = '0; e_go = '0;
    for (int i = 0; i < NR; i++) e_r[i*DW +: DW] = m_r[i];
    if (m_run) begin
      e_go[m_sel] = 1'b1;
      e_ptr = k_ptr[m_sel*NP*AW +: NP*AW];
      e_st  = k_data_store[m_sel*NP*DW +: NP*DW];
      e_w   = k_w_en[m_sel*NP +: NP];
      e_rd  = k_r_en[m_sel*NP +: NP];
      e_av  = k_avail[m_sel*NP +: NP];
      e_rb[m_sel*NP*AW +: NP*AW] = mem_region_begin;
      e_re[m_sel*NP*AW +: NP*AW] = mem_region_end;
      e_dl[m_sel*NP*DW +: NP*DW] = mem_data_load;
      e_md[m_sel*NP +: NP]       = mem_done;
    end
    chk("done", 256'(done), 256'(m_fin));
    chk("err", 256'(err), 256'(m_fin && m_err));
    chk("busy", 256'(busy), 256'(m_run));
    chk("port_ctr", 256'(port_ctr), 256'(m_ctr));
    chk("k_go", 256'(k_go), 256'(e_go));
    chk("r", 256'(r), 256'(e_r));
    chk("mem_ptr", 256'(mem_ptr), 256'(e_ptr));
    chk("mem_data_store", 256'(mem_data_store), 256'(e_st));
    chk("mem_strobes", 256'({mem_w_en, mem_r_en, mem_avail}), 256'({e_w, e_rd, e_av}));
    chk("k_region_begin", 256'(k_region_begin), 256'(e_rb));
    chk("k_region_end", 256'(k_region_end), 256'(e_re));
    chk("k_data_load", 256'(k_data_load), 256'(e_dl));
    chk("k_mem_done", 256'(k_mem_done), 256'(e_md));
  end

  task automatic run_job(input int o);
    avail = 1'b1; op = OW'(o);
    cyc();
    cyc();
    k_done = '0; k_done[o] = 1'b1;
    cyc();
    k_done = '0; avail = 1'b0;
    cyc();
  endtask

  initial begin
    rst_l = 1'b0; avail = 1'b0; op = '0; k_done = '0;
    rnd();
    @(posedge clk); #1;
    rst_l = 1'b1;
    @(negedge clk);
    chk("reset_done", 256'(done), 256'(0));
    chk("reset_ctr", 256'(port_ctr), 256'(0));
    chk("reset_mem_ptr", 256'(mem_ptr), 256'(0));

    // op=2: one-hot go one cycle after avail
    avail = 1'b1; op = 4'd2;
    cyc();
    @(negedge clk);
    chk("kgo_op2", 256'(k_go), 256'(4'b0100));
    repeat (3) cyc();
    k_done = 4'b0100;
    cyc();
    k_done = '0; avail = 1'b0;
    cyc();

    // kernel 0 result latch and done/avail handshake
    avail = 1'b1; op = 4'd0;
    cyc();
    repeat (2) cyc();
    k_r[5*DW +: DW] = 32'h3F800000;
    k_done = 4'b0001;
    cyc();
    k_done = '0;
    @(negedge clk);
    chk("done_after_kdone", 256'(done), 256'(1));
    chk("r5_latched", 256'(r[5*DW +: DW]), 256'(32'h3F800000));
    repeat (3) cyc();
    @(negedge clk);
    chk("done_held", 256'(done), 256'(1));
    avail = 1'b0;
    cyc();
    @(negedge clk);
    chk("done_released", 256'(done), 256'(0));
    chk("ctr_after_2", 256'(port_ctr), 256'(2));

    // bad op
    avail = 1'b1; op = 4'd9;
    cyc();
    @(negedge clk);
    chk("badop_err", 256'({done, err}), 256'(2'b11));
    chk("badop_no_go", 256'(k_go), 256'(0));
    chk("badop_r5", 256'(r[5*DW +: DW]), 256'(32'h3F800000));
    repeat (2) cyc();
    avail = 1'b0;
    cyc();
    @(negedge clk);
    chk("ctr_after_badop", 256'(port_ctr), 256'(3));

    // kernel 1 ignores foreign k_done and op/avail changes
    avail = 1'b1; op = 4'd1;
    cyc();
    k_done = 4'b1000; op = 4'd3;
    cyc();
    k_done = '0; avail = 1'b0; op = 4'd5;
    cyc();
    @(negedge clk);
    chk("k1_still_busy", 256'(busy), 256'(1));
    chk("k1_go", 256'(k_go), 256'(4'b0010));
    chk("k1_mem_ptr", 256'(mem_ptr), 256'(k_ptr[1*NP*AW +: NP*AW]));
    k_done = 4'b0010;
    cyc();
    k_done = '0;
    cyc();
    @(negedge clk);
    chk("ctr_after_4", 256'(port_ctr), 256'(4));

    // counter wrap
    for (int j = 0; j < 11; j++) run_job(j % NK);
    @(negedge clk);
    chk("ctr_15", 256'(port_ctr), 256'(15));
    run_job(3);
    @(negedge clk);
    chk("ctr_wrap", 256'(port_ctr), 256'(0));

    // asynchronous reset mid-RUN
    avail = 1'b1; op = 4'd3;
    cyc();
    cyc();
    #2 rst_l = 1'b0;
    #1;
    chk("rst_kgo", 256'(k_go), 256'(0));
    chk("rst_mem", 256'({mem_ptr, mem_avail, mem_w_en}), 256'(0));
    chk("rst_busy", 256'(busy), 256'(0));
    avail = 1'b0;
    @(posedge clk); #1;
    rst_l = 1'b1;
    @(negedge clk);
    chk("rst_r5", 256'(r[5*DW +: DW]), 256'(0));

`ifdef FPU_JM_TIMEOUT_EN
    avail = 1'b1; op = 4'd0;
    cyc();
    repeat (9) cyc();
    @(negedge clk);
    chk("to_still_run", 256'(busy), 256'(1));
    cyc();
    @(negedge clk);
    chk("to_err", 256'({done, err, k_go}), 256'({1'b1, 1'b1, 4'b0000}));
    avail = 1'b0;
    cyc();
    avail = 1'b1; op = 4'd2;
    cyc();
    repeat (9) cyc();
    k_done = 4'b0100;
    cyc();
    k_done = '0;
    @(negedge clk);
    chk("to_done_wins", 256'({done, err}), 256'(2'b10));
    avail = 1'b0;
    cyc();
`endif

    repeat (2) cyc();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fpu_job_dispatcher.md
Name: fpu_job_dispatcher

Overview:
- Parametrised job manager for the FPU.
- Accepts one operation request at a time and decodes the op code to one of NUM_KERNELS kernel FSMs (linear fwd/bwd, flatten fwd/bwd, ...).
- Routes NUM_PORTS memory-handle bundles between the memory system and the selected kernel.
- Latches the kernel register file on completion; handshakes done/avail with the upstream scheduler; counts completed jobs.

Parameters:
NUM_KERNELS, 4, number of attached kernel FSMs; op code k selects kernel k
NUM_PORTS, 4, memory-handle bundles per kernel (a, b, c, d, ...)
ADDR_W, 32, ptr / region_begin / region_end width
DATA_W, 32, data_load / data_store and register width
NUM_REGS, 32, intermediate registers exported by each kernel
OP_W, 4, op code width
CTR_W, 4, port_ctr width
TIMEOUT_CYCLES, 65535, watchdog limit (optional feature only)

Ports:
clk  in  1  clock
rst_l  in  1  asynchronous active-low reset
avail  in  1  upstream job valid; held high until done is seen
op  in  OP_W  operation code, sampled in IDLE when avail=1
done  out  1  job finished (success or error); held until avail drops
err  out  1  job failed (bad op or timeout); valid while done=1
busy  out  1  a kernel is running
port_ctr  out  CTR_W  completed-job counter, wraps
mem_region_begin/mem_region_end  in  NUM_PORTS*ADDR_W  per-port region bounds from memory
mem_data_load  in  NUM_PORTS*DATA_W  per-port load data
mem_done  in  NUM_PORTS  per-port memory done
mem_w_en/mem_r_en/mem_avail  out  NUM_PORTS  per-port request strobes to memory
mem_ptr  out  NUM_PORTS*ADDR_W  per-port address
mem_data_store  out  NUM_PORTS*DATA_W  per-port store data
k_go  out  NUM_KERNELS  one-hot kernel start
k_done  in  NUM_KERNELS  kernel completion
k_w_en/k_r_en/k_avail  in  NUM_KERNELS*NUM_PORTS  kernel-side strobes
k_ptr  in  NUM_KERNELS*NUM_PORTS*ADDR_W  kernel-side address
k_data_store  in  NUM_KERNELS*NUM_PORTS*DATA_W  kernel-side store data
k_region_begin/k_region_end  out  NUM_KERNELS*NUM_PORTS*ADDR_W  fan-out of region bounds to kernels
k_data_load  out  NUM_KERNELS*NUM_PORTS*DATA_W  fan-out of load data to kernels
k_mem_done  out  NUM_KERNELS*NUM_PORTS  fan-out of memory done to kernels
k_r  in  NUM_KERNELS*NUM_REGS*DATA_W  kernel register files
r  out  NUM_REGS*DATA_W  latched result registers

Behaviour:
- Reset (async, rst_l=0): state=IDLE, sel=0, done=err=busy=0, k_go=0, port_ctr=0, r=0, all mem_* outputs 0. Reset mid-job drops k_go immediately and abandons the job.
- States:
  - IDLE: avail=1 and op<NUM_KERNELS -> RUN, sel<=op. avail=1 and op>=NUM_KERNELS -> ERR. Otherwise stay.
  - RUN: k_go[sel]=1, busy=1. k_done[sel]=1 -> DONE, and r<=k_r[sel] on the same edge.
  - DONE / ERR: done=1; err=1 in ERR only. avail=1 -> stay; avail=0 -> IDLE and port_ctr<=port_ctr+1 (wraps to 0 at all-ones).
- Latency:
  - avail to k_go: 1 cycle.
  - k_done to done: 1 cycle.
  - done low 1 cycle after avail falls.
- Mux (combinational):
  - In RUN, mem_* outputs = kernel[sel] outputs, and kernel[sel] inputs = mem_* inputs.
  - Non-selected kernels, and all kernels outside RUN, receive zeros; mem_* outputs are 0 outside RUN.
- k_done from a non-selected kernel is ignored; k_done[sel] outside RUN is ignored.
- op and avail changes during RUN are ignored; sel is stable for the whole job.
- r holds the last result until the next successful completion; ERR does not modify r.

Optional Feature:
FPU_JM_TIMEOUT_EN
- Defined:
  - A cycle counter clears on RUN entry and increments each RUN cycle.
  - When it reaches TIMEOUT_CYCLES without k_done[sel], go to ERR; k_go drops and r is unchanged.
  - k_done[sel] in that same cycle wins (goes to DONE).
- Undefined: no counter; RUN waits indefinitely.

Decomposition:
- Package fpu_jm_pkg: state enum (IDLE, RUN, DONE, ERR), op code constants (LINEAR_FW=0, LINEAR_BW=1, FLATTEN_FW=2, FLATTEN_BW=3), bundle width localparams.
- Sub-module fpu_port_mux: parametrised NUM_KERNELS-to-1 memory-bundle mux/demux driven by sel and a run-enable.

Test Plan:
- Reset with no job -> all outputs 0, port_ctr=0; avail=1, op=2 -> k_go=4'b0100 next cycle, mem_ptr tracks kernel 2 ptr values.
- Kernel 0 run, k_r[0] reg5=32'h3F800000, k_done[0] pulse -> done=1 next cycle, r reg5=32'h3F800000; avail held 3 cycles -> done held; avail drops -> IDLE, port_ctr=1.
- op=4'd9 with NUM_KERNELS=4 -> ERR: done=1, err=1, no k_go, r unchanged, port_ctr increments on release.
- During kernel 1 run, pulse k_done[3] and toggle op -> ignored, state stays RUN, mem outputs still from kernel 1.
- 16 back-to-back jobs with CTR_W=4 -> port_ctr wraps 15->0; rst_l low mid-RUN -> k_go=0, mem_* outputs 0 immediately.
- With FPU_JM_TIMEOUT_EN and TIMEOUT_CYCLES=10, kernel never finishes -> ERR after 10 RUN cycles; k_done[sel] on cycle 10 -> DONE, err=0.
